me_frame_scheduler: RTL and testbench

- Sequences the ME core across a whole frame. Walks macroblock coordinates in raster order and drives the core's enable for one block at a time.
- Captures each block's MSAD, column and row into a result FIFO with a valid/ready handshake to downstream.
- Sits between the frame-level control/config interface and the ME top. Provides a watchdog and a done/busy status.

---
 rtl/me_frame_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_me_frame_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_scheduler.sv
// rtl/me_frame_scheduler.sv - frame-level macroblock sequencer for the ME core
//
// Purpose:
//   Walks macroblock coordinates of a frame in raster order and enables the
//   ME core for one block at a time. The MSAD result of each block is queued,
//   together with its coordinates, in a first-word fall-through result FIFO.
//   A per-block watchdog aborts the frame when the core never answers.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-low reset
//   start_i           frame start pulse, honoured only while idle
//   frame_w_i         frame width in blocks (latched at start)
//   frame_h_i         frame height in blocks (latched at start)
//   me_en_o           ME core enable, high for the whole block
//   me_block_start_o  pulse on the first cycle of each block
//   me_data_valid_i   ME core result strobe
//   me_msad_i         ME core minimum SAD
//   me_msad_col_i     ME core MSAD column
//   me_msad_row_i     ME core MSAD row
//   res_valid_o       result FIFO head valid
//   res_ready_i       downstream accepts the head entry
//   res_data_o        {blk_y, blk_x, msad_row, msad_col, msad}
//   busy_o            scheduler is not idle
//   done_o            one-cycle pulse when a frame has fully drained
//   timeout_o         sticky watchdog flag, cleared by the next start
module me_frame_scheduler #(
  parameter int SAD_BIT_WIDTH  = 14,
  parameter int COORD_W        = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [COORD_W-1:0]                     frame_w_i,
  input  logic [COORD_W-1:0]                     frame_h_i,
  output logic                                   me_en_o,
  output logic                                   me_block_start_o,
  input  logic                                   me_data_valid_i,
  input  logic [SAD_BIT_WIDTH-1:0]               me_msad_i,
  input  logic [4:0]                             me_msad_col_i,
  input  logic [4:0]                             me_msad_row_i,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [2*COORD_W+10+SAD_BIT_WIDTH-1:0]  res_data_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   timeout_o
);

  localparam int DATA_W = 2*COORD_W + 10 + SAD_BIT_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]    TO_C    = WD_W'(TIMEOUT_CYCLES);
  localparam logic [COORD_W-1:0] ONE_C   = COORD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_NEXT,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame geometry and current block
  logic [COORD_W-1:0] r_w;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  logic [WD_W-1:0]    r_wd;
  logic               r_timeout;
  logic               r_done;

  // Result FIFO storage
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_fifo_nempty;
  logic               w_has_room;
  logic               w_room_or_pop;
  logic               w_last_x;
  logic               w_last_blk;
  logic               w_wd_hit;
  logic [WD_W-1:0]    w_wd_inc;
  logic [DATA_W-1:0]  w_push_data;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign w_last_x   = (r_x == r_w - ONE_C);
  assign w_last_blk = w_last_x && (r_y == r_h - ONE_C);

  // Saturating watchdog; the hit is taken on the cycle whose increment
  // reaches the limit, so a block gets exactly TIMEOUT_CYCLES BUSY cycles.
  assign w_wd_inc = (r_wd == TO_C) ? r_wd : r_wd + WD_W'(1);
  assign w_wd_hit = (w_wd_inc == TO_C);

  assign w_fifo_nempty = (r_count != '0);
  assign w_pop         = w_fifo_nempty && res_ready_i;
  // Only BUSY pushes; ISSUE is entered only with a free slot, so the push
  // can never overflow.
  assign w_push        = (r_state == S_BUSY) && me_data_valid_i;
  assign w_has_room    = (r_count < DEPTH_C);
  assign w_room_or_pop = w_has_room || w_pop;
  assign w_push_data   = {r_y, r_x, me_msad_row_i, me_msad_col_i, me_msad_i};

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    me_en_o          = 1'b0;
    me_block_start_o = 1'b0;
    busy_o           = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if ((frame_w_i == '0) || (frame_h_i == '0)) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        me_en_o          = 1'b1;
        me_block_start_o = 1'b1;
        w_state_nxt      = S_BUSY;
      end
      S_BUSY: begin
        me_en_o = 1'b1;
        // A result in the same cycle as the watchdog hit still counts.
        if (me_data_valid_i) begin
          w_state_nxt = S_NEXT;
        end else if (w_wd_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NEXT: begin
        if (w_last_blk) begin
          w_state_nxt = S_FINISH;
        end else if (w_has_room) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_room_or_pop) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_FINISH: begin
        if (!w_fifo_nempty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, coordinates, watchdog, status flags and FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_wd      <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // done is raised together with the return to IDLE so busy_o and
      // done_o change on the same edge.
      r_done  <= (r_state == S_FINISH) && (w_state_nxt == S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_w       <= frame_w_i;
            r_h       <= frame_h_i;
            r_x       <= '0;
            r_y       <= '0;
            r_timeout <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_wd <= '0;
        end
        S_BUSY: begin
          r_wd <= w_wd_inc;
          if (!me_data_valid_i && w_wd_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_NEXT: begin
          // The last block leaves the counters in range.
          if (!w_last_blk) begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + ONE_C;
            end else begin
              r_x <= r_x + ONE_C;
            end
          end
        end
        default: begin
        end
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign res_valid_o = w_fifo_nempty;
  assign res_data_o  = w_fifo_nempty ? r_mem[r_rd_ptr] : '0;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb/tb_me_frame_scheduler.sv - scoreboard bench for me_frame_scheduler
module tb_me_frame_scheduler;

  localparam int SW    = 14;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 1023;
  localparam int DW    = 2*CW + 10 + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [CW-1:0] frame_w_i;
  logic [CW-1:0] frame_h_i;
  logic          me_en_o;
  logic          me_block_start_o;
  logic          me_data_valid_i;
  logic [SW-1:0] me_msad_i;
  logic [4:0]    me_msad_col_i;
  logic [4:0]    me_msad_row_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [DW-1:0] res_data_o;
  logic          busy_o;
  logic          done_o;
  logic          timeout_o;

  logic          model_dv;
  logic          spur_dv;
  assign me_data_valid_i = model_dv | spur_dv;

  always #5 clk = ~clk;

  me_frame_scheduler #(
    .SAD_BIT_WIDTH(SW),
    .COORD_W(CW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .frame_w_i(frame_w_i),
    .frame_h_i(frame_h_i),
    .me_en_o(me_en_o),
    .me_block_start_o(me_block_start_o),
    .me_data_valid_i(me_data_valid_i),
    .me_msad_i(me_msad_i),
    .me_msad_col_i(me_msad_col_i),
    .me_msad_row_i(me_msad_row_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o(res_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];

  // Shared bench state (each variable has a single writing process)
  int me_mode = 0;     // 0: core silent, 1: fixed 20-cycle latency, 2: random 1..8
  int ready_mode = 1;  // 0: stall, 1: always ready, 2: random
  int blk_cnt = 0;     // block starts seen (model)
  int base = 0;        // blk_cnt at the current frame start (main)
  int frame_w_m = 1;   // frame width used by the reference (main)
  int gen = 0;         // bumped by main on reset to abandon pending responses
  int chk_gap = 0;
  int pops = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ME core model: answers each block start and records the expected result
  // from the raster index of that block within the frame.
  initial begin : me_model
    int lat, idx, g, bx, by, last_dv_cyc;
    logic [SW-1:0] m;
    logic [4:0] c, r;
    model_dv = 1'b0;
    me_msad_i = '0;
    me_msad_col_i = '0;
    me_msad_row_i = '0;
    last_dv_cyc = 0;
    forever begin
      @(negedge clk);
      if (me_block_start_o) begin
        idx = blk_cnt - base;
        blk_cnt++;
        if (chk_gap != 0 && idx > 0) check("block_gap", cyc - last_dv_cyc, 2);
        if (me_mode != 0) begin
          lat = (me_mode == 1) ? 20 : $urandom_range(1, 8);
          g = gen;
          for (int i = 0; i < lat && g == gen; i++) @(negedge clk);
          if (g == gen) begin
            m = SW'($urandom);
            c = 5'($urandom);
            r = 5'($urandom);
            bx = idx % frame_w_m;
            by = idx / frame_w_m;
            model_dv = 1'b1;
            me_msad_i = m;
            me_msad_col_i = c;
            me_msad_row_i = r;
            exp_q.push_back({by[CW-1:0], bx[CW-1:0], r, c, m});
            last_dv_cyc = cyc;
            @(negedge clk);
            model_dv = 1'b0;
          end
        end
      end
    end
  end

  // Downstream ready driver
  initial begin : ready_drv
    res_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: res_ready_i = 1'b0;
        1: res_ready_i = 1'b1;
        default: res_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Result monitor / scoreboard
  initial begin : monitor
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", res_valid_o, 1);
          check("stall_data_held", res_data_o, prev_data);
        end
        if (res_valid_o && res_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=no_entry", res_data_o);
          end else begin
            exp = exp_q.pop_front();
            check("result", res_data_o, exp);
          end
          pops++;
        end
        prev_stall = res_valid_o && !res_ready_i;
        prev_data = res_data_o;
      end
    end
  end

  // done_o always coincides with busy_o having dropped
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done_o) begin
        done_cnt++;
        check("busy_low_with_done", busy_o, 0);
      end
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic start_frame(input int w, input int h);
    frame_w_m = (w == 0) ? 1 : w;
    base = blk_cnt;
    frame_w_i = CW'(w);
    frame_h_i = CW'(h);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input int nblk);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done_cnt != d0) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_done_wait actual=no_done required=done_o", name);
    end
    repeat (3) tick();
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_results_drained"}, exp_q.size(), 0);
    check({name, "_blocks_issued"}, blk_cnt - base, nblk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_me_en"}, me_en_o, 0);
    check({name, "_blk_start"}, me_block_start_o, 0);
    check({name, "_res_valid"}, res_valid_o, 0);
    check({name, "_res_data"}, res_data_o, 0);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_done"}, done_o, 0);
    check({name, "_timeout"}, timeout_o, 0);
  endtask

  task automatic wait_hold(input string name, input int nres);
    bit got;
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (exp_q.size() == nres && !me_en_o) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_hold_wait actual=%0d required=%0d", name, exp_q.size(), nres);
    end
  endtask

  initial begin : main
    int n, d0, b0, p0;
    bit seen, en_seen, got;
    rst = 1'b0;
    start_i = 1'b0;
    frame_w_i = '0;
    frame_h_i = '0;
    spur_dv = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // 1: 2x2 frame, fixed latency, always ready
    me_mode = 1;
    ready_mode = 1;
    chk_gap = 1;
    start_frame(2, 2);
    wait_done("t1", 2000, 4);
    chk_gap = 0;

    // 2: 3x2 frame with downstream stalled until the FIFO fills
    me_mode = 2;
    ready_mode = 0;
    start_frame(3, 2);
    wait_hold("t2", DEPTH);
    en_seen = 0;
    repeat (20) begin
      @(negedge clk);
      en_seen = en_seen | me_en_o | me_block_start_o;
    end
    check("t2_hold_me_en", en_seen, 0);
    check("t2_hold_blocks", blk_cnt - base, DEPTH);
    check("t2_hold_busy", busy_o, 1);
    p0 = pops;
    tick();
    ready_mode = 1;
    tick();
    ready_mode = 0;
    @(negedge clk);
    check("t2_issue_after_pop", me_block_start_o, 1);
    tick();
    check("t2_single_pop", pops - p0, 1);
    ready_mode = 1;
    wait_done("t2", 2000, 6);

    // 3: 1x1 frame with a silent core -> watchdog
    me_mode = 0;
    d0 = done_cnt;
    start_frame(1, 1);
    n = 0;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (me_en_o) begin
        n++;
        seen = 1;
      end else if (seen) begin
        break;
      end
    end
    check("t3_en_cycles", n, TO + 1);
    check("t3_timeout_flag", timeout_o, 1);
    check("t3_busy_after_timeout", busy_o, 0);
    repeat (5) tick();
    check("t3_no_result", res_valid_o, 0);
    check("t3_no_done", done_cnt - d0, 0);
    me_mode = 2;
    start_frame(1, 1);
    @(negedge clk);
    check("t3_timeout_cleared", timeout_o, 0);
    wait_done("t3", 500, 1);

    // 4: zero-width frame
    d0 = done_cnt;
    b0 = blk_cnt;
    got = 0;
    start_frame(0, 5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done_o) got = 1;
    end
    check("t4_done_within_2", got, 1);
    repeat (3) tick();
    check("t4_no_block_start", blk_cnt - b0, 0);
    check("t4_done_once", done_cnt - d0, 1);

    // 5: spurious strobes and a start request during BUSY
    me_mode = 2;
    ready_mode = 0;
    spur_dv = 1'b1;
    repeat (2) tick();
    spur_dv = 1'b0;
    tick();
    check("t5_idle_spurious", res_valid_o, 0);
    start_frame(3, 2);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (me_en_o && !me_block_start_o) got = 1;
    end
    tick();
    frame_w_i = CW'(1);
    frame_h_i = CW'(1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_hold("t5", DEPTH);
    tick();
    spur_dv = 1'b1;
    repeat (3) tick();
    spur_dv = 1'b0;
    check("t5_hold_queue", exp_q.size(), DEPTH);
    ready_mode = 1;
    wait_done("t5", 2000, 6);

    // 6: reset during block 2 of a 2x2 frame, then restart
    me_mode = 1;
    ready_mode = 0;
    start_frame(2, 2);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (blk_cnt - base == 2) got = 1;
    end
    check("t6_reached_block2", blk_cnt - base, 2);
    repeat (5) tick();
    gen++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t6_mid_reset");
    exp_q.delete();
    tick();
    ready_mode = 1;
    start_frame(2, 2);
    wait_done("t6", 2000, 4);

    // Random frames with random downstream backpressure
    me_mode = 2;
    ready_mode = 2;
    for (int k = 0; k < 5; k++) begin
      int rw, rh;
      rw = $urandom_range(1, 4);
      rh = $urandom_range(1, 3);
      start_frame(rw, rh);
      wait_done("rand", 3000, rw * rh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
